// File: rtl/osecpu_pkg.sv
// osecpu_pkg: opcodes, CR bit indices, sequencer state encodings and the
// opcode-to-length decode shared by the OSECPU fetch path.
// No logic; constants and one pure function only.
package osecpu_pkg;

  localparam logic [7:0] OP_LBSET  = 8'h01;
  localparam logic [7:0] OP_LIMM32 = 8'h02;
  localparam logic [7:0] OP_HLT    = 8'h3f;

  localparam int BIT_CR_HLT = 0;
  localparam int BIT_CR_ILL = 1;

  // Width of the raw length decode; wide enough to express lengths beyond
  // MAX_WORDS so an over-long opcode can be detected rather than truncated.
  localparam int OP_LEN_W = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Instruction length in words for an opcode. New multi-word opcodes are
  // added here only; the sequencer needs no other change.
  function automatic logic [OP_LEN_W-1:0] op_len(input logic [7:0] op);
    case (op)
      OP_LIMM32, OP_LBSET: op_len = 4'd2;
      default:             op_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/osecpu_instr_buf.sv
// osecpu_instr_buf: MAX_WORDS-word instruction register file with clear,
// write-at-current-count, word counter and registered instruction length.
// Latency: write visible the cycle after wr_en. No backpressure (always accepts).
// Ports: clk/reset; clr (cnt and words to 0); wr_en/wr_data (store at cnt,
// cnt++); len_we/len_d (load instr_len); cnt, instr_len, instr outputs.
module osecpu_instr_buf #(
  parameter int WORD_WIDTH = 32,
  parameter int MAX_WORDS  = 3,
  parameter int LEN_W      = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clr,
  input  logic                            wr_en,
  input  logic [WORD_WIDTH-1:0]           wr_data,
  input  logic                            len_we,
  input  logic [LEN_W-1:0]                len_d,
  output logic [LEN_W-1:0]                cnt,
  output logic [LEN_W-1:0]                instr_len,
  output logic [MAX_WORDS*WORD_WIDTH-1:0] instr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      instr_len <= '0;
      instr     <= '0;
    end else if (clr) begin
      // instr_len is left alone: it is always reloaded with word 0.
      cnt   <= '0;
      instr <= '0;
    end else begin
      if (wr_en) begin
        for (int k = 0; k < MAX_WORDS; k++) begin
          if (cnt == LEN_W'(k)) begin
            instr[k*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
          end
        end
        cnt <= LEN_W'(cnt + 1'b1);
      end
      if (len_we) begin
        instr_len <= len_d;
      end
    end
  end

endmodule

// File: rtl/osecpu_fetch_seq.sv
// osecpu_fetch_seq: variable-length instruction fetch/execute sequencer.
// Latency: L-word instruction needs L accepted words + 1 cycle to reach EXEC.
// Backpressure: mem_valid low = wait state (all state holds); EXEC holds until exec_done.
// Ports: clk, reset; mem_req/mem_addr/mem_valid/mem_rdata memory handshake;
// instr/instr_len/exec_valid/exec_done/br_taken/br_target execute side;
// resume leaves HALT; pc, cr, state are architectural/status outputs.
// LEN_OVERRIDE nonzero replaces the opcode length decode (bring-up builds).
module osecpu_fetch_seq
  import osecpu_pkg::*;
#(
  parameter int PC_WIDTH     = 16,
  parameter int WORD_WIDTH   = 32,
  parameter int MAX_WORDS    = 3,
  parameter int OP_WIDTH     = 8,
  parameter int LEN_OVERRIDE = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              mem_req,
  output logic [PC_WIDTH-1:0]               mem_addr,
  input  logic                              mem_valid,
  input  logic [WORD_WIDTH-1:0]             mem_rdata,
  output logic [MAX_WORDS*WORD_WIDTH-1:0]   instr,
  output logic [$clog2(MAX_WORDS+1)-1:0]    instr_len,
  output logic                              exec_valid,
  input  logic                              exec_done,
  input  logic                              br_taken,
  input  logic [PC_WIDTH-1:0]               br_target,
  input  logic                              resume,
  output logic [PC_WIDTH-1:0]               pc,
  output logic [7:0]                        cr,
  output logic [1:0]                        state
);

  localparam int LEN_W = $clog2(MAX_WORDS+1);

  state_t              st;
  logic [LEN_W-1:0]    cnt;
  logic [OP_WIDTH-1:0] fetch_op;
  logic [OP_WIDTH-1:0] exec_op;
  logic [OP_LEN_W-1:0] word_len;
  logic                accept;
  logic                first_word;
  logic                len_bad;
  logic                last_word;
  logic                exec_fire;
  logic                is_hlt;
  logic                buf_clr;

  assign accept     = (st == ST_FETCH) && mem_valid;
  assign first_word = (cnt == '0);
  assign fetch_op   = mem_rdata[WORD_WIDTH-1 -: OP_WIDTH];
  assign exec_op    = instr[WORD_WIDTH-1 -: OP_WIDTH];
  assign is_hlt     = (exec_op == OP_WIDTH'(OP_HLT));
  assign exec_fire  = (st == ST_EXEC) && exec_done;

  always_comb begin
    word_len = op_len(8'(fetch_op));
    if (LEN_OVERRIDE != 0) begin
      word_len = OP_LEN_W'(LEN_OVERRIDE);
    end
  end

  assign len_bad = (word_len == '0) || (word_len > OP_LEN_W'(MAX_WORDS));

  // Word 0 decides completion from the fresh decode; later words compare
  // against the length registered when word 0 was accepted.
  assign last_word = first_word ? (word_len == OP_LEN_W'(1))
                                : (LEN_W'(cnt + 1'b1) == instr_len);

  // Leaving HALT must also start from an empty buffer: an illegal word 0
  // or a halted instruction is still sitting in it.
  assign buf_clr = (exec_fire && !is_hlt) || ((st == ST_HALT) && resume);

  osecpu_instr_buf #(
    .WORD_WIDTH (WORD_WIDTH),
    .MAX_WORDS  (MAX_WORDS),
    .LEN_W      (LEN_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clr       (buf_clr),
    .wr_en     (accept),
    .wr_data   (mem_rdata),
    .len_we    (accept && first_word),
    .len_d     (LEN_W'(word_len)),
    .cnt       (cnt),
    .instr_len (instr_len),
    .instr     (instr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= ST_FETCH;
      pc <= '0;
      cr <= '0;
    end else begin
      case (st)
        ST_FETCH: begin
          if (mem_valid) begin
            pc <= pc + 1'b1;
            if (first_word && len_bad) begin
              cr[BIT_CR_ILL] <= 1'b1;
              cr[BIT_CR_HLT] <= 1'b1;
              st             <= ST_HALT;
            end else if (last_word) begin
              st <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            // Branch applies even when the instruction is a halt.
            if (br_taken) begin
              pc <= br_target;
            end
            if (is_hlt) begin
              cr[BIT_CR_HLT] <= 1'b1;
              st             <= ST_HALT;
            end else begin
              st <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          if (resume) begin
            cr <= '0;
            st <= ST_FETCH;
          end
        end
        default: st <= ST_FETCH;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign mem_req    = (st == ST_FETCH);
  assign mem_addr   = mem_req ? pc : '0;
  assign exec_valid = (st == ST_EXEC);
  assign state      = st;

endmodule

// File: tb/tb_osecpu_fetch_seq.sv
// Testbench for osecpu_fetch_seq: directed scenarios plus a randomized
// program run checked against an instruction-level reference model.
module tb_osecpu_fetch_seq;
  import osecpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        mem_req, mem_valid, exec_valid, exec_done, br_taken, resume;
  logic [15:0] mem_addr, br_target, pc;
  logic [31:0] mem_rdata;
  logic [95:0] instr;
  logic [1:0]  instr_len, state;
  logic [7:0]  cr;

  logic        ill_req, ill_valid, ill_exec_valid;
  logic [15:0] ill_addr, ill_pc;
  logic [31:0] ill_rdata;
  logic [95:0] ill_instr;
  logic [1:0]  ill_len, ill_state;
  logic [7:0]  ill_cr;

  logic [31:0] mem [0:65535];
  always_comb mem_rdata = mem[mem_addr];
  always_comb ill_rdata = mem[ill_addr];

  int vectors = 0;
  int miscompares = 0;

  osecpu_fetch_seq u_dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .instr(instr),
    .instr_len(instr_len), .exec_valid(exec_valid), .exec_done(exec_done),
    .br_taken(br_taken), .br_target(br_target), .resume(resume), .pc(pc),
    .cr(cr), .state(state)
  );

  // Every opcode decodes to 4 words, beyond MAX_WORDS = 3.
  osecpu_fetch_seq #(.LEN_OVERRIDE(4)) u_ill (
    .clk(clk), .reset(reset), .mem_req(ill_req), .mem_addr(ill_addr),
    .mem_valid(ill_valid), .mem_rdata(ill_rdata), .instr(ill_instr),
    .instr_len(ill_len), .exec_valid(ill_exec_valid), .exec_done(exec_done),
    .br_taken(br_taken), .br_target(br_target), .resume(resume), .pc(ill_pc),
    .cr(ill_cr), .state(ill_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_valid = 1'b0; ill_valid = 1'b0; exec_done = 1'b0;
    br_taken = 1'b0; br_target = '0; resume = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (pc !== 16'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0000", pc); end
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state); end
    vectors++; if (instr !== 96'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", instr); end
    vectors++; if (instr_len !== 2'd0) begin miscompares++; $display("FAIL reset_len got %0d want 0", instr_len); end
    vectors++; if (cr !== 8'h00) begin miscompares++; $display("FAIL reset_cr got %h want 00", cr); end
    vectors++; if (exec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_exec_valid got %b want 0", exec_valid); end
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL reset_mem_req got %b want 1", mem_req); end
  endtask

  // 1-word op then HLT, with mem_valid and exec_done tied high.
  task automatic test_hlt_seq();
    logic [1:0] es [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2};
    logic [15:0] ep [6] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2};
    logic        er [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0]  ec [6] = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h1};
    mem[0] = {8'h10, 24'h123456};
    mem[1] = {OP_HLT, 24'h0};
    do_reset();
    mem_valid = 1'b1; exec_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if ({state, pc, mem_req, cr} !== {es[c], ep[c], er[c], ec[c]}) begin
        miscompares++;
        $display("FAIL hlt_seq cycle %0d got state=%0d pc=%h req=%b cr=%h want state=%0d pc=%h req=%b cr=%h",
                 c, state, pc, mem_req, cr, es[c], ep[c], er[c], ec[c]);
      end
      tick();
    end
    mem_valid = 1'b0; exec_done = 1'b0;
  endtask

  // LIMM32 with two wait states before each word; then a branch to 0x40.
  task automatic test_limm_wait_branch();
    int rise;
    mem[0] = {OP_LIMM32, 24'h000055};
    mem[1] = 32'hDEADBEEF;
    mem[16'h40] = {8'h10, 24'h0};
    do_reset();
    rise = -1;
    for (int c = 0; c < 10; c++) begin
      if (rise < 0 && exec_valid) rise = c;
      mem_valid = (c == 2 || c == 5);
      tick();
    end
    vectors++; if (rise !== 6) begin miscompares++; $display("FAIL limm_rise got %0d want 6", rise); end
    vectors++; if (instr_len !== 2'd2) begin miscompares++; $display("FAIL limm_len got %0d want 2", instr_len); end
    vectors++; if (instr[63:32] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL limm_word1 got %h want deadbeef", instr[63:32]); end
    vectors++; if (instr[31:0] !== mem[0]) begin miscompares++; $display("FAIL limm_word0 got %h want %h", instr[31:0], mem[0]); end
    vectors++; if (pc !== 16'd2) begin miscompares++; $display("FAIL limm_pc got %h want 0002", pc); end
    vectors++; if (exec_valid !== 1'b1) begin miscompares++; $display("FAIL limm_hold got %b want 1", exec_valid); end
    exec_done = 1'b1; br_taken = 1'b1; br_target = 16'h0040;
    tick();
    exec_done = 1'b0; br_taken = 1'b0;
    vectors++; if (mem_addr !== 16'h0040) begin miscompares++; $display("FAIL branch_addr got %h want 0040", mem_addr); end
    vectors++; if (instr !== 96'h0) begin miscompares++; $display("FAIL branch_clear got %h want 0", instr); end
  endtask

  // Continues from the branch: a 2-word op at 0xFFFF wraps to address 0.
  task automatic test_wrap();
    mem[16'hFFFF] = {OP_LBSET, 24'h00ABCD};
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0; exec_done = 1'b1; br_taken = 1'b1; br_target = 16'hFFFF;
    tick();
    exec_done = 1'b0; br_taken = 1'b0;
    vectors++; if (mem_addr !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_addr0 got %h want ffff", mem_addr); end
    mem_valid = 1'b1;
    tick();
    vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL wrap_addr1 got %h want 0000", mem_addr); end
    tick();
    mem_valid = 1'b0;
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL wrap_state got %0d want 1", state); end
    vectors++; if (pc !== 16'h0001) begin miscompares++; $display("FAIL wrap_pc got %h want 0001", pc); end
    vectors++; if (instr[63:0] !== {mem[0], mem[16'hFFFF]}) begin miscompares++; $display("FAIL wrap_instr got %h want %h", instr[63:0], {mem[0], mem[16'hFFFF]}); end
  endtask

  task automatic test_reset_mid();
    mem[0] = {OP_LIMM32, 24'h000001};
    do_reset();
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    vectors++; if (pc !== 16'd1 || state !== 2'd0) begin miscompares++; $display("FAIL mid_pre got pc=%h state=%0d want pc=0001 state=0", pc, state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({pc, state, instr, exec_valid, instr_len} !== {16'h0, 2'd0, 96'h0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL mid_reset got pc=%h state=%0d instr=%h ev=%b len=%0d want all 0", pc, state, instr, exec_valid, instr_len);
    end
  endtask

  task automatic test_illegal();
    mem[0] = {8'h10, 24'h0};
    do_reset();
    ill_valid = 1'b1;
    tick();
    ill_valid = 1'b0;
    vectors++; if (ill_state !== 2'd2) begin miscompares++; $display("FAIL ill_state got %0d want 2", ill_state); end
    vectors++; if (ill_cr !== 8'h03) begin miscompares++; $display("FAIL ill_cr got %h want 03", ill_cr); end
    vectors++; if (ill_pc !== 16'd1) begin miscompares++; $display("FAIL ill_pc got %h want 0001", ill_pc); end
    vectors++; if (ill_req !== 1'b0) begin miscompares++; $display("FAIL ill_req got %b want 0", ill_req); end
    tick();
    vectors++; if (ill_state !== 2'd2) begin miscompares++; $display("FAIL ill_stay got %0d want 2", ill_state); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    vectors++; if (ill_cr !== 8'h00) begin miscompares++; $display("FAIL ill_resume_cr got %h want 00", ill_cr); end
    vectors++; if (ill_req !== 1'b1 || ill_addr !== 16'd1) begin miscompares++; $display("FAIL ill_resume_fetch got req=%b addr=%h want req=1 addr=0001", ill_req, ill_addr); end
    vectors++; if (state !== 2'd0 || pc !== 16'd0) begin miscompares++; $display("FAIL resume_ignored got state=%0d pc=%h want 0 0000", state, pc); end
  endtask

  // Random program, random wait states, random exec latency and branches.
  task automatic test_random();
    logic [31:0] w;
    logic [15:0] mpc;
    logic [95:0] exp_instr;
    logic [7:0]  op;
    int L, acc, cyc, d;
    for (int a = 0; a < 65536; a++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[31:24] = OP_LIMM32;
        1: w[31:24] = OP_LBSET;
        default: ;
      endcase
      if (w[31:24] == OP_HLT) w[31:24] = 8'h00;
      mem[a] = w;
    end
    do_reset();
    mpc = 16'h0;
    for (int n = 0; n < 40; n++) begin
      w = mem[mpc];
      op = w[31:24];
      L = (op == OP_LIMM32 || op == OP_LBSET) ? 2 : 1;
      exp_instr = '0;
      for (int k = 0; k < L; k++) exp_instr[k*32 +: 32] = mem[16'(mpc + 16'(k))];
      acc = 0; cyc = 0;
      while (!exec_valid && cyc < 64) begin
        mem_valid = 1'($urandom_range(0, 1));
        if (mem_valid) acc++;
        tick(); cyc++;
      end
      mem_valid = 1'b0;
      vectors++; if (exec_valid !== 1'b1) begin miscompares++; $display("FAIL rand_exec_timeout instr %0d got %b want 1", n, exec_valid); end
      vectors++; if (acc !== L) begin miscompares++; $display("FAIL rand_words instr %0d got %0d want %0d", n, acc, L); end
      vectors++; if (instr_len !== 2'(L)) begin miscompares++; $display("FAIL rand_len instr %0d got %0d want %0d", n, instr_len, L); end
      vectors++; if (instr !== exp_instr) begin miscompares++; $display("FAIL rand_instr instr %0d got %h want %h", n, instr, exp_instr); end
      mpc = 16'(mpc + 16'(L));
      vectors++; if (pc !== mpc) begin miscompares++; $display("FAIL rand_pc instr %0d got %h want %h", n, pc, mpc); end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        mem_valid = 1'($urandom_range(0, 1));
        tick();
      end
      mem_valid = 1'b0;
      vectors++; if (state !== 2'd1 || pc !== mpc) begin miscompares++; $display("FAIL rand_hold instr %0d got state=%0d pc=%h want 1 %h", n, state, pc, mpc); end
      exec_done = 1'b1;
      br_taken = 1'($urandom_range(0, 1));
      br_target = 16'($urandom);
      tick();
      exec_done = 1'b0;
      if (br_taken) mpc = br_target;
      br_taken = 1'b0;
      vectors++;
      if (state !== 2'd0 || pc !== mpc || instr !== 96'h0) begin
        miscompares++;
        $display("FAIL rand_next instr %0d got state=%0d pc=%h instr=%h want 0 %h 0", n, state, pc, instr, mpc);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_valid = 1'b0; ill_valid = 1'b0; exec_done = 1'b0;
    br_taken = 1'b0; br_target = '0; resume = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
    test_reset();
    test_hlt_seq();
    test_limm_wait_branch();
    test_wrap();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
